// File: rtl/lsu_mem_master_if.sv
// Purpose: core request/response and memory-controller bus of the LSU, bundled as one interface.
// Latency: no logic inside; timing is set by whichever module drives the master modport.
// Backpressure: req_valid/req_ready and resp_valid/resp_ready; the memory side has no stall input.
interface lsu_mem_master_if;
  // core request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // core response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // memory controller port
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata;

  // view taken by the LSU itself
  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  // view taken by the surrounding core and memory controller
  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Purpose: RV32 load/store initiator; one access outstanding, word-aligned memory access with byte mask.
// Latency: request to response LATENCY+1 cycles (illegal requests: 1 cycle, no memory access).
// Backpressure: req_ready only in IDLE; resp_valid and payload held until resp_ready, any length.
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into errors.
module lsu_mem_master #(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Counter only has to hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Funct3 legality, plus the optional alignment trap.
  function automatic logic req_legal(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    if (st) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3[1:0] == 2'b01) && off[0]) ok = 1'b0;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) ok = 1'b0;
`else
    if (off == 2'b11 && off == 2'b00) ok = 1'b0; // never true; keeps off referenced in this build
`endif
    return ok;
  endfunction

  // Byte enables for a store: size mask shifted to the byte offset, bytes past lane 3 dropped.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] base;
    logic [7:0] wide;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    wide = {4'b0000, base} << off;
    return wide[3:0];
  endfunction

  // Align the addressed byte to lane 0 (upper lanes fill with 0) then extend by size.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Next-state and datapath capture for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          f3_d    = bus.req_funct3;
          off_d   = bus.req_addr[1:0];
          rdata_d = 32'h0;
          if (req_legal(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
            // Memory-side fields are only refreshed for accesses that actually go out.
            waddr_d = bus.req_addr[31:2];
            wdata_d = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
            wmask_d = bus.req_store ? store_mask(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          if (!store_q) begin
            rdata_d = load_extract(f3_q, off_q, bus.mem_rdata);
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          // Clear the payload so an idle response channel reads as zero.
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      waddr_q <= 30'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign bus.mem_valid  = (state_q == ACCESS);
  assign bus.mem_wen    = (state_q == ACCESS) && store_q;
  assign bus.mem_raddr  = {waddr_q, 2'b00};
  assign bus.mem_waddr  = {waddr_q, 2'b00};
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = {4'b0000, wmask_q};

endmodule

// File: tb/tb_lsu_mem_master.sv
// Purpose: self-checking bench for lsu_mem_master at LATENCY=1 and LATENCY=3.
// Latency: checks request-to-response timing and mem_valid duration per access.
// Backpressure: holds resp_ready low for 0..5 cycles and checks response stability.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if if1();
  lsu_mem_master_if if3();

  lsu_mem_master #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  lsu_mem_master #(.LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

  // Shared stimulus; handshakes are steered to the selected instance only.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.resp_ready = resp_ready & ~sel;
  assign if3.resp_ready = resp_ready & sel;
  assign if1.req_store  = req_store;
  assign if3.req_store  = req_store;
  assign if1.req_funct3 = req_funct3;
  assign if3.req_funct3 = req_funct3;
  assign if1.req_addr   = req_addr;
  assign if3.req_addr   = req_addr;
  assign if1.req_wdata  = req_wdata;
  assign if3.req_wdata  = req_wdata;
  assign if1.mem_rdata  = mem_rdata;
  assign if3.mem_rdata  = mem_rdata;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen;
  logic [31:0] o_resp_rdata, o_mem_raddr, o_mem_waddr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  assign o_req_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign o_resp_valid = sel ? if3.resp_valid : if1.resp_valid;
  assign o_resp_err   = sel ? if3.resp_err   : if1.resp_err;
  assign o_resp_rdata = sel ? if3.resp_rdata : if1.resp_rdata;
  assign o_mem_valid  = sel ? if3.mem_valid  : if1.mem_valid;
  assign o_mem_wen    = sel ? if3.mem_wen    : if1.mem_wen;
  assign o_mem_raddr  = sel ? if3.mem_raddr  : if1.mem_raddr;
  assign o_mem_waddr  = sel ? if3.mem_waddr  : if1.mem_waddr;
  assign o_mem_wdata  = sel ? if3.mem_wdata  : if1.mem_wdata;
  assign o_mem_wmask  = sel ? if3.mem_wmask  : if1.mem_wmask;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } exp_t;

  // Reference model: byte-by-byte view of the access, independent of the RTL datapath.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int sz, off;
    logic legal;
    logic [31:0] v;
    e = '{1'b0, 32'h0, 4'h0, 32'h0};
    off = int'(a[1:0]);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((off % sz) != 0) legal = 1'b0;
`endif
    if (!legal) begin
      e.err = 1'b1;
      return e;
    end
    if (st) begin
      for (int k = 0; k < sz; k++) if (off + k < 4) e.wmask[off + k] = 1'b1;
      e.wdata = wd << (8 * off);
    end else begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) if (off + k < 4) v[8*k +: 8] = rd[8*(off+k) +: 8];
      if (!f3[2] && sz < 4 && v[8*sz-1]) for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
      e.rdata = v;
    end
    return e;
  endfunction

  // One complete transaction on the selected instance, with timing and payload checks.
  task automatic do_txn(input logic s, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        input logic e_err, input logic [31:0] e_rdata, input logic [3:0] e_wmask,
                        input logic [31:0] e_wdata);
    int lat, k, nmv;
    lat = s ? 3 : 1;
    sel = s;
    mem_rdata = rd;
    #1;
    chk("req_ready_idle", o_req_ready, 1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom_range(0, 7));
    nmv = 0; k = 1;
    while (k < 20 && !o_resp_valid) begin
      if (o_mem_valid) begin
        nmv++;
        chk("mem_wen", o_mem_wen, st);
        chk("mem_raddr", o_mem_raddr, {a[31:2], 2'b00});
        chk("mem_waddr", o_mem_waddr, {a[31:2], 2'b00});
        if (st) begin
          chk("mem_wmask", o_mem_wmask, {4'h0, e_wmask});
          chk("mem_wdata", o_mem_wdata, e_wdata);
        end
      end
      chk("req_ready_busy", o_req_ready, 0);
      @(posedge clk); #1;
      k++;
    end
    chk("resp_cycle", k, e_err ? 1 : lat + 1);
    chk("mem_valid_cycles", nmv, e_err ? 0 : lat);
    chk("resp_valid", o_resp_valid, 1);
    chk("resp_err", o_resp_err, e_err);
    chk("resp_rdata", o_resp_rdata, e_rdata);
    chk("mem_valid_in_resp", o_mem_valid, 0);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_valid", o_resp_valid, 1);
      chk("hold_resp_rdata", o_resp_rdata, e_rdata);
      chk("hold_resp_err", o_resp_err, e_err);
      chk("hold_req_ready", o_req_ready, 0);
      chk("hold_mem_valid", o_mem_valid, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("req_ready_after", o_req_ready, 1);
    chk("resp_valid_after", o_resp_valid, 0);
    chk("mem_valid_after", o_mem_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, o_req_ready, 1);
    chk({tag, "_resp_valid"}, o_resp_valid, 0);
    chk({tag, "_resp_err"}, o_resp_err, 0);
    chk({tag, "_resp_rdata"}, o_resp_rdata, 0);
    chk({tag, "_mem_valid"}, o_mem_valid, 0);
    chk({tag, "_mem_wen"}, o_mem_wen, 0);
    chk({tag, "_mem_raddr"}, o_mem_raddr, 0);
    chk({tag, "_mem_waddr"}, o_mem_waddr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_mem_wmask"}, {24'h0, o_mem_wmask}, 0);
  endtask

  typedef struct {
    logic        s;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[$];
  exp_t e;
  logic r_s, r_st;
  logic [2:0] r_f3;
  logic [31:0] r_a, r_wd, r_rd;

  initial begin
    // Hand-computed vectors.
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 1, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF1234, 0, 1'b0, 32'h00000080, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0, 0, 1'b0, 32'h0, 4'hC, 32'hABCD0000});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 32'h12345678, 5, 1'b0, 32'h12345678, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 32'h80000000, 32'h0, 32'hFFFFFFFF, 2, 1'b1, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b111, 32'h80000000, 32'h0, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80010000, 0, 1'b0, 32'hFFFF8001, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3'b101, 32'h80000002, 32'h0, 32'h80010000, 1, 1'b0, 32'h00008001, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 32'h80000001, 32'h000000A5, 32'h0, 0, 1'b0, 32'h0, 4'h2, 32'h0000A500});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 32'h80000000, 32'h11111111, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1'b0, 1'b0, 3'b010, 32'h80000001, 32'h0, 32'hAABBCCDD, 0, 1'b1, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 32'h80000003, 32'h0000ABCD, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 3'b001, 32'h80000003, 32'h0, 32'h80FF1234, 0, 1'b1, 32'h0, 4'h0, 32'h0});
`else
    tbl.push_back('{1'b0, 1'b0, 3'b010, 32'h80000001, 32'h0, 32'hAABBCCDD, 0, 1'b0, 32'h00AABBCC, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 32'h80000003, 32'h0000ABCD, 32'h0, 0, 1'b0, 32'h0, 4'h8, 32'hCD000000});
    tbl.push_back('{1'b0, 1'b0, 3'b001, 32'h80000003, 32'h0, 32'h80FF1234, 0, 1'b0, 32'h00000080, 4'h0, 32'h0});
`endif

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_reset_vals("rst1");
    sel = 1'b1; #1; chk_reset_vals("rst3");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      do_txn(tbl[i].s, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].dly,
             tbl[i].err, tbl[i].rdata, tbl[i].wmask, tbl[i].wdata);
    end

    // Reset during the second ACCESS cycle of a LATENCY=3 store.
    sel = 1'b1; #1;
    chk("rstseq_ready", o_req_ready, 1);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h80000008; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstseq_acc1", o_mem_valid, 1);
    @(posedge clk); #1;
    chk("rstseq_acc2", o_mem_valid, 1);
    chk("rstseq_wdata", o_mem_wdata, 32'h11223344);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_vals("midrst");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", o_resp_valid, 0);
      chk("midrst_no_mem", o_mem_valid, 0);
    end
    do_txn(1'b1, 1'b0, 3'b010, 32'h80000020, 32'h0, 32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, 4'h0, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      r_s  = 1'($urandom_range(0, 1));
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      e = model(r_st, r_f3, r_a, r_wd, r_rd);
      do_txn(r_s, r_st, r_f3, r_a, r_wd, r_rd, int'($urandom_range(0, 3)),
             e.err, e.rdata, e.wmask, e.wdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
